// File: rtl/cs161_multicycle_ctrl.sv
// cs161_multicycle_ctrl
// Main control FSM for the multicycle cs161 datapath. It sequences
// fetch / decode / execute / memory / writeback over one shared instruction+data
// memory and drives the datapath mux selects and write enables. Memory accesses
// complete on mem_ready. A wait watchdog aborts any access that stalls too long.
//
// Optional feature: define CS161_MC_JUMP_EN to decode opcode 000010 (j) into the
// JUMP state. Without it, j is reported as an illegal opcode.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RST    | 0  held in reset / first cycle after release, all outputs 0
// FETCH  | 1  read instruction at PC, PC+4 computed, IR/PC load on ready
// DECODE | 2  opcode decode, branch target precomputed in ALUOut
// MEMADR | 3  lw/sw effective address A + sign-ext imm
// MEMRD  | 4  data read at ALUOut, waits for mem_ready
// MEMWB  | 5  MDR written to rt
// MEMWR  | 6  data write at ALUOut, waits for mem_ready
// EXEC   | 7  R-type ALU operation, funct-decoded
// ALUWB  | 8  ALUOut written to rd
// BRANCH | 9  beq compare, PC <- ALUOut when zero
// JUMP   | 10 PC <- jump target (only with CS161_MC_JUMP_EN)
// 11-15  |    unused, recover to FETCH with outputs 0
`timescale 1ns/1ps

module cs161_multicycle_ctrl #(
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instr_opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
`ifdef CS161_MC_JUMP_EN
    ,
    S_JUMP   = 4'd10
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [TO_W-1:0] WAIT_LIMIT = TO_W'(MEM_TIMEOUT);

  // Moore part of the control word. in_fetch marks FETCH so the ready-gated
  // IR/PC strobes can be formed without re-decoding the state.
  typedef struct packed {
    logic       in_fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.in_fetch  = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
`ifdef CS161_MC_JUMP_EN
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  state_t          state_q;
  state_t          state_nxt;
  ctrl_t           ctrl_q;
  logic [TO_W-1:0] wait_cnt;
  logic            in_wait;
  logic            nxt_is_wait;
  logic            abort;
  logic            illegal;

  // The beq outcome is applied by the datapath through pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  assign in_wait     = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR});
  assign nxt_is_wait = (state_nxt inside {S_FETCH, S_MEMRD, S_MEMWR});
  // A ready on the limit cycle still completes normally.
  assign abort       = in_wait && (wait_cnt == WAIT_LIMIT) && !mem_ready;

  // Next-state selection; an aborted access always falls back to FETCH.
  always_comb begin
    state_nxt = S_FETCH;
    illegal   = 1'b0;
    case (state_q)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
`ifdef CS161_MC_JUMP_EN
          OP_J:         state_nxt = S_JUMP;
`endif
          default: begin
            state_nxt = S_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_nxt = (instr_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)  state_nxt = S_MEMWB;
        else if (abort) state_nxt = S_FETCH;
        else            state_nxt = S_MEMRD;
      end
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR: begin
        if (mem_ready || abort) state_nxt = S_FETCH;
        else                    state_nxt = S_MEMWR;
      end
      S_EXEC:   state_nxt = S_ALUWB;
      S_ALUWB:  state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // State, registered control word and memory-wait watchdog counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RST;
      ctrl_q   <= '0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode_ctrl(state_nxt);
      // An abort that stays in FETCH is a fresh retry, so it restarts the count.
      if (nxt_is_wait && ((state_nxt != state_q) || abort))
        wait_cnt <= '0;
      else if (in_wait && !mem_ready)
        wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  assign pc_write      = ctrl_q.pc_write | (ctrl_q.in_fetch & mem_ready);
  assign ir_write      = ctrl_q.in_fetch & mem_ready;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign state         = state_q;
  assign illegal_op    = (state_q == S_DECODE) && illegal;
  assign mem_timeout   = abort;

endmodule
